// File: rtl/riscv_pkg.sv
// Shared RISC-V execution constants: ALU opcode encodings and index-width helper
// used by the shared-ALU arbiter and its requesters.
package riscv_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ADD_OP  = 4'h0;
    localparam logic [ALUOP_W-1:0] SUB_OP  = 4'h1;
    localparam logic [ALUOP_W-1:0] AND_OP  = 4'h2;
    localparam logic [ALUOP_W-1:0] OR_OP   = 4'h3;
    localparam logic [ALUOP_W-1:0] XOR_OP  = 4'h4;
    localparam logic [ALUOP_W-1:0] SLL_OP  = 4'h5;
    localparam logic [ALUOP_W-1:0] SRL_OP  = 4'h6;
    localparam logic [ALUOP_W-1:0] SRA_OP  = 4'h7;
    localparam logic [ALUOP_W-1:0] SLT_OP  = 4'h8;
    localparam logic [ALUOP_W-1:0] SLTU_OP = 4'h9;

    // Width of an index into n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping
// N-1 -> 0. Produces a one-hot grant plus the granted index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = riscv_pkg::idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N))
                w_sum = w_sum - (IW+1)'(N);
            w_cand = w_sum[IW-1:0];
            if (!o_vld && i_req[w_cand]) begin
                o_vld         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NREQ harts: round-robin issue, one op in flight
// per hart, and a tag pipe that routes each result back to its owner.
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DWIDTH      = 32,
    parameter int ALUOP_WIDTH = ALUOP_W,
    parameter int ALU_LATENCY = 1,
    localparam int IW         = idx_w(NREQ)
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic [NREQ-1:0]               i_req_valid,
    input  logic [NREQ*DWIDTH-1:0]        i_req_op1,
    input  logic [NREQ*DWIDTH-1:0]        i_req_op2,
    input  logic [NREQ*ALUOP_WIDTH-1:0]   i_req_aluop,
    output logic [NREQ-1:0]               o_req_ready,
    output logic [DWIDTH-1:0]             o_alu_op1,
    output logic [DWIDTH-1:0]             o_alu_op2,
    output logic [ALUOP_WIDTH-1:0]        o_alu_aluop,
    input  logic [DWIDTH-1:0]             i_alu_result,
    output logic                          o_rsp_valid,
    output logic [IW-1:0]                 o_rsp_id,
    output logic [DWIDTH-1:0]             o_rsp_data,
    output logic                          o_idle
);

    // Stage 0 sits alongside the o_alu_* register, then one stage per ALU cycle,
    // so the last stage lines up with i_alu_result.
    localparam int TD = ALU_LATENCY + 1;

    logic [NREQ-1:0]                   r_busy;
    logic [IW-1:0]                     r_ptr;
    logic [TD-1:0]                     r_tag_vld;
    logic [TD-1:0][IW-1:0]             r_tag_id;

    logic [NREQ-1:0][DWIDTH-1:0]       w_op1;
    logic [NREQ-1:0][DWIDTH-1:0]       w_op2;
    logic [NREQ-1:0][ALUOP_WIDTH-1:0]  w_aluop;
    logic [NREQ-1:0]                   w_elig;
    logic [NREQ-1:0]                   w_gnt_raw;
    logic [NREQ-1:0]                   w_gnt;
    logic [NREQ-1:0]                   w_clr;
    logic [IW-1:0]                     w_gidx;
    logic [IW-1:0]                     w_tag_id;
    logic                              w_gvld_raw;
    logic                              w_gvld;

    assign w_op1   = i_req_op1;
    assign w_op2   = i_req_op2;
    assign w_aluop = i_req_aluop;
    assign w_elig  = i_req_valid & ~r_busy;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt_raw),
        .o_idx (w_gidx),
        .o_vld (w_gvld_raw)
    );

    // Grants are combinational from i_req_valid, so hold them off during reset.
    assign w_gvld      = w_gvld_raw & i_rst_n;
    assign w_gnt       = w_gnt_raw & {NREQ{i_rst_n}};
    assign w_tag_id    = w_gvld ? w_gidx : '0;
    assign o_req_ready = w_gnt;

    assign o_rsp_valid = r_tag_vld[TD-1];
    assign o_rsp_id    = r_tag_id[TD-1];
    assign o_rsp_data  = o_rsp_valid ? i_alu_result : '0;
    assign o_idle      = ~|r_busy & ~|r_tag_vld;

    always_comb begin
        w_clr = '0;
        if (o_rsp_valid)
            w_clr[o_rsp_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy      <= '0;
            r_ptr       <= '0;
            r_tag_vld   <= '0;
            r_tag_id    <= '0;
            o_alu_op1   <= '0;
            o_alu_op2   <= '0;
            o_alu_aluop <= '0;
        end else begin
            // Grant needs ~busy and clear needs busy, so they never hit the same bit.
            r_busy    <= (r_busy & ~w_clr) | w_gnt;
            r_tag_vld <= {r_tag_vld[TD-2:0], w_gvld};
            r_tag_id  <= {r_tag_id[TD-2:0], w_tag_id};
            if (w_gvld) begin
                r_ptr       <= (w_gidx == IW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
                o_alu_op1   <= w_op1[w_gidx];
                o_alu_op2   <= w_op2[w_gidx];
                o_alu_aluop <= w_aluop[w_gidx];
            end else begin
                o_alu_op1   <= '0;
                o_alu_op2   <= '0;
                o_alu_aluop <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model; a second instance runs with a 3-cycle ALU.
module tb_alu_arbiter;
    import riscv_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]    valid = '0;
    logic [N*W-1:0]  op1 = '0, op2 = '0;
    logic [N*OW-1:0] aluop = '0;
    logic [N-1:0]    ready;
    logic [W-1:0]    alu_op1, alu_op2, alu_res;
    logic [OW-1:0]   alu_aluop;
    logic            rsp_valid, idle;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_data;

    logic [N-1:0]    b_valid = '0;
    logic [N*W-1:0]  b_op1 = '0, b_op2 = '0;
    logic [N*OW-1:0] b_aluop = '0;
    logic [N-1:0]    b_ready;
    logic [W-1:0]    b_alu_op1, b_alu_op2, b_alu_res, b_p1, b_p2;
    logic [OW-1:0]   b_alu_aluop;
    logic            b_rsp_valid, b_idle;
    logic [1:0]      b_rsp_id;
    logic [W-1:0]    b_rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(N), .DWIDTH(W), .ALUOP_WIDTH(OW), .ALU_LATENCY(1)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .i_req_op1(op1), .i_req_op2(op2),
        .i_req_aluop(aluop), .o_req_ready(ready), .o_alu_op1(alu_op1), .o_alu_op2(alu_op2),
        .o_alu_aluop(alu_aluop), .i_alu_result(alu_res), .o_rsp_valid(rsp_valid),
        .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_idle(idle));

    alu_arbiter #(.NREQ(N), .DWIDTH(W), .ALUOP_WIDTH(OW), .ALU_LATENCY(3)) dut_l3 (
        .clk(clk), .i_rst_n(rst_n), .i_req_valid(b_valid), .i_req_op1(b_op1), .i_req_op2(b_op2),
        .i_req_aluop(b_aluop), .o_req_ready(b_ready), .o_alu_op1(b_alu_op1), .o_alu_op2(b_alu_op2),
        .o_alu_aluop(b_alu_aluop), .i_alu_result(b_alu_res), .o_rsp_valid(b_rsp_valid),
        .o_rsp_id(b_rsp_id), .o_rsp_data(b_rsp_data), .o_idle(b_idle));

    function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            ADD_OP:  alu_f = a + b;
            SUB_OP:  alu_f = a - b;
            AND_OP:  alu_f = a & b;
            OR_OP:   alu_f = a | b;
            XOR_OP:  alu_f = a ^ b;
            SLL_OP:  alu_f = a << b[4:0];
            SRL_OP:  alu_f = a >> b[4:0];
            SRA_OP:  alu_f = $signed(a) >>> b[4:0];
            SLT_OP:  alu_f = {31'b0, $signed(a) < $signed(b)};
            SLTU_OP: alu_f = {31'b0, a < b};
            default: alu_f = '0;
        endcase
    endfunction

    // Behavioural ALUs: 1-cycle and 3-cycle
    always @(posedge clk) alu_res <= alu_f(alu_aluop, alu_op1, alu_op2);
    always @(posedge clk) begin
        b_p1      <= alu_f(b_alu_aluop, b_alu_op1, b_alu_op2);
        b_p2      <= b_p1;
        b_alu_res <= b_p2;
    end

    // Reference model: per-hart busy flags, rotating pointer, queue of pending responses.
    typedef struct { int due; int id; logic [W-1:0] data; } rsp_t;
    bit         m_busy [N];
    int         m_ptr;
    int         cyc;
    rsp_t       m_q [$];
    int         e_g;
    logic [N-1:0] e_ready;
    logic       e_rv, e_idle;
    logic [1:0] e_id;
    logic [W-1:0] e_data;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        m_ptr = 0;
        m_q.delete();
    endtask

    task automatic model_eval();
        e_g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (e_g < 0 && valid[j] && !m_busy[j]) e_g = j;
        end
        e_ready = (e_g >= 0) ? N'(1 << e_g) : '0;
        e_idle  = (m_q.size() == 0);
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            e_rv = 1'b1; e_id = 2'(m_q[0].id); e_data = m_q[0].data;
        end else begin
            e_rv = 1'b0; e_id = '0; e_data = '0;
        end
    endtask

    task automatic model_commit();
        rsp_t r;
        if (e_rv) begin
            m_busy[e_id] = 0;
            void'(m_q.pop_front());
        end
        if (e_g >= 0) begin
            m_busy[e_g] = 1;
            m_ptr  = (e_g + 1) % N;
            r.due  = cyc + 2;
            r.id   = e_g;
            r.data = alu_f(aluop[e_g*OW +: OW], op1[e_g*W +: W], op2[e_g*W +: W]);
            m_q.push_back(r);
        end
        cyc++;
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic adv();
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        aluop[i*OW +: OW] = op;
        op1[i*W +: W]     = a;
        op2[i*W +: W]     = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; valid = '0; b_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        valid = '1; b_valid = '1;
        #2;
        n_cmp++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready got=%b exp=0000", ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL rst_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
        n_cmp++; if (alu_op1 !== '0 || alu_aluop !== '0) begin n_bad++; $display("FAIL rst_alu got=%h/%h exp=0/0", alu_op1, alu_aluop); end
        n_cmp++; if (b_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_l3_ready got=%b exp=0000", b_ready); end
        @(negedge clk);
        rst_n = 1'b1; valid = '0; b_valid = '0;
        model_reset();
    endtask

    task automatic test_single_add();
        set_req(0, ADD_OP, 32'd5, 32'd7);
        valid = 4'b0001;
        settle();
        n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL add_ready got=%b exp=0001", ready); end
        adv();
        valid = '0;
        for (int c = 1; c <= 3; c++) begin
            settle();
            if (c == 1) begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early_rsp got=%b exp=0", rsp_valid); end
                n_cmp++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_aluop !== ADD_OP) begin
                    n_bad++; $display("FAIL add_alu_ops got=%0d,%0d,%0d exp=5,7,%0d", alu_op1, alu_op2, alu_aluop, ADD_OP); end
            end else if (c == 2) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd12) begin
                    n_bad++; $display("FAIL add_rsp got=%b/%0d/%0d exp=1/0/12", rsp_valid, rsp_id, rsp_data); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || idle !== 1'b1) begin
                    n_bad++; $display("FAIL add_after got=%b/%h/%b exp=0/0/1", rsp_valid, rsp_data, idle); end
            end
            adv();
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] g, ex;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, ADD_OP, W'(i), W'(10*i));
        valid = '1;
        for (int c = 0; c < 6; c++) begin
            settle();
            g = ready;
            if (c < 4) begin
                ex = N'(1 << c);
                n_cmp++; if (ready !== ex) begin n_bad++; $display("FAIL four_grant c=%0d got=%b exp=%b", c, ready, ex); end
            end
            if (c >= 2) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c-2) || rsp_data !== W'(11*(c-2))) begin
                    n_bad++; $display("FAIL four_rsp c=%0d got=%b/%0d/%0d exp=1/%0d/%0d", c, rsp_valid, rsp_id, rsp_data, c-2, 11*(c-2)); end
            end
            adv();
            valid = valid & ~g;
        end
    endtask

    task automatic test_single_rate();
        logic [N-1:0] ex;
        set_req(2, SUB_OP, 32'd9, 32'd4);
        valid = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            settle();
            ex = (c % 3 == 0) ? 4'b0100 : 4'b0000;
            n_cmp++; if (ready !== ex) begin n_bad++; $display("FAIL rate_grant c=%0d got=%b exp=%b", c, ready, ex); end
            n_cmp++; if (rsp_valid !== (c % 3 == 2)) begin n_bad++; $display("FAIL rate_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, c % 3 == 2); end
            if (c % 3 == 2) begin
                n_cmp++; if (rsp_id !== 2'd2 || rsp_data !== 32'd5) begin
                    n_bad++; $display("FAIL rate_rsp c=%0d got=%0d/%0d exp=2/5", c, rsp_id, rsp_data); end
            end
            adv();
        end
        valid = '0;
        settle(); adv();
    endtask

    task automatic test_alternate();
        int n1, n3, last;
        n1 = 0; n3 = 0; last = -1;
        set_req(1, OR_OP, 32'h10, 32'h01);
        set_req(3, AND_OP, 32'hFF, 32'h0F);
        valid = 4'b1010;
        for (int c = 0; c < 12; c++) begin
            settle();
            n_cmp++; if (ready !== e_ready) begin n_bad++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, ready, e_ready); end
            n_cmp++; if (rsp_valid !== e_rv) begin n_bad++; $display("FAIL alt_rsp c=%0d got=%b exp=%b", c, rsp_valid, e_rv); end
            if (ready != 0) begin
                int g;
                g = (ready == 4'b0010) ? 1 : 3;
                if (g == 1) n1++; else n3++;
                n_cmp++; if (g == last) begin n_bad++; $display("FAIL alt_repeat c=%0d got=%0d exp=other", c, g); end
                last = g;
            end
            adv();
        end
        n_cmp++; if (n1 < 3 || n3 < 3) begin n_bad++; $display("FAIL alt_starve got=%0d/%0d exp>=3/3", n1, n3); end
        valid = '0;
        repeat (3) begin settle(); adv(); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, XOR_OP, W'($urandom), W'($urandom));
        valid = '1;
        settle();
        n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_g0 got=%b exp=0001", ready); end
        adv();
        valid = 4'b1110;
        settle();
        n_cmp++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL rmid_g1 got=%b exp=0010", ready); end
        adv();
        rst_n = 1'b0; valid = '1;
        model_reset();
        #2;
        n_cmp++; if (rsp_valid !== 1'b0 || idle !== 1'b1 || ready !== 4'b0000) begin
            n_bad++; $display("FAIL rmid_in_rst got=%b/%b/%b exp=0/1/0000", rsp_valid, idle, ready); end
        @(negedge clk);
        rst_n = 1'b1; valid = '0;
        for (int c = 0; c < 4; c++) begin
            settle();
            n_cmp++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                n_bad++; $display("FAIL rmid_stale c=%0d got=%b/%b exp=0/1", c, rsp_valid, idle); end
            adv();
        end
        valid = '1;
        settle();
        n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL rmid_restart got=%b exp=0001", ready); end
        adv();
        valid = '0;
        repeat (3) begin settle(); adv(); end
    endtask

    task automatic test_latency3();
        logic exv;
        b_aluop[0 +: OW] = XOR_OP;
        b_op1[0 +: W] = 32'hF0;
        b_op2[0 +: W] = 32'hFF;
        b_valid = 4'b0001;
        #2;
        n_cmp++; if (b_ready !== 4'b0001) begin n_bad++; $display("FAIL l3_grant got=%b exp=0001", b_ready); end
        @(negedge clk);
        b_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            #2;
            exv = (c == 4);
            n_cmp++; if (b_rsp_valid !== exv) begin n_bad++; $display("FAIL l3_rsp_valid c=%0d got=%b exp=%b", c, b_rsp_valid, exv); end
            if (c == 4) begin
                n_cmp++; if (b_rsp_id !== 2'd0 || b_rsp_data !== 32'h0F) begin
                    n_bad++; $display("FAIL l3_rsp got=%0d/%h exp=0/0000000f", b_rsp_id, b_rsp_data); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 410; c++) begin
            valid = (c < 400) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++) set_req(i, OW'($urandom_range(0, 9)), W'($urandom), W'($urandom));
            settle();
            n_cmp++; if (ready !== e_ready) begin n_bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, ready, e_ready); end
            n_cmp++; if (rsp_valid !== e_rv) begin n_bad++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, e_rv); end
            n_cmp++; if (rsp_data !== e_data) begin n_bad++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, e_data); end
            if (e_rv) begin
                n_cmp++; if (rsp_id !== e_id) begin n_bad++; $display("FAIL rnd_rsp_id c=%0d got=%0d exp=%0d", c, rsp_id, e_id); end
            end
            n_cmp++; if (idle !== e_idle) begin n_bad++; $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, idle, e_idle); end
            adv();
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_single_add();
        test_all_four();
        test_single_rate();
        test_alternate();
        test_reset_mid();
        test_latency3();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
